// File: rtl/tlul_pkg.sv
// tlul_pkg: shared TL-UL types and constants for the TL-UL adapter blocks.
//   tl_h2d_t         host-to-device payload (A channel plus d_ready)
//   tl_d2h_t         device-to-host payload (D channel plus a_ready)
//   err_gate_state_e state encoding for tlul_err_gate
//   ERR_GATE_CNT_W   width of the rejected-request counter
package tlul_pkg;

  localparam int unsigned TL_AW  = 32;
  localparam int unsigned TL_DW  = 32;
  localparam int unsigned TL_DBW = TL_DW / 8;
  localparam int unsigned TL_AIW = 8;
  localparam int unsigned TL_DIW = 1;
  localparam int unsigned TL_SZW = 2;

  localparam int unsigned ERR_GATE_CNT_W = 16;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic                  a_valid;
    tl_a_op_e              a_opcode;
    logic [2:0]            a_param;
    logic [TL_SZW-1:0]     a_size;
    logic [TL_AIW-1:0]     a_source;
    logic [TL_AW-1:0]      a_address;
    logic [TL_DBW-1:0]     a_mask;
    logic [TL_DW-1:0]      a_data;
    logic                  d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic                  d_valid;
    tl_d_op_e              d_opcode;
    logic [2:0]            d_param;
    logic [TL_SZW-1:0]     d_size;
    logic [TL_AIW-1:0]     d_source;
    logic [TL_DIW-1:0]     d_sink;
    logic [TL_DW-1:0]      d_data;
    logic                  d_error;
    logic                  a_ready;
  } tl_d2h_t;

  typedef enum logic [1:0] {
    ErrGateIdle  = 2'd0,
    ErrGateDrain = 2'd1,
    ErrGateResp  = 2'd2
  } err_gate_state_e;

  // Response opcode that answers a given request opcode.
  function automatic tl_d_op_e rsp_opcode(input tl_a_op_e op);
    return (op == Get) ? AccessAckData : AccessAck;
  endfunction

endpackage

// File: rtl/tlul_outst_cnt.sv
// tlul_outst_cnt: saturating up/down counter of transactions in flight.
//   clk, rst  clock, asynchronous active-high reset
//   inc       one transaction issued this cycle
//   dec       one transaction retired this cycle
//   cnt       current number in flight (0..MaxOutstanding)
//   full      cnt == MaxOutstanding
//   empty     cnt == 0
module tlul_outst_cnt #(
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned CntW           = $clog2(MaxOutstanding + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inc,
  input  logic            dec,
  output logic [CntW-1:0] cnt,
  output logic            full,
  output logic            empty
);

  assign full  = (cnt == CntW'(MaxOutstanding));
  assign empty = (cnt == '0);

  // Simultaneous issue and retire leave the count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && !dec && !full) begin
      cnt <= cnt + CntW'(1);
    end else if (dec && !inc && !empty) begin
      cnt <= cnt - CntW'(1);
    end
  end

endmodule

// File: rtl/tlul_err_gate.sv
// tlul_err_gate: forwards legal TL-UL requests to the device and answers
// illegal ones locally with d_error=1, after draining device traffic so the
// host sees responses in request order.
//   clk_i, rst_i  clock, asynchronous active-high reset
//   tl_h_i/tl_h_o host-side request in / response out
//   err_i         same-cycle legality verdict for tl_h_i A beat (1 = illegal)
//   tl_d_o/tl_d_i device-side request out / response in
//   err_cnt_o     rejected-request count (0 unless TLUL_ERR_GATE_CNT_EN)
//   err_clr_i     synchronous clear of err_cnt_o
// Build option: define TLUL_ERR_GATE_CNT_EN to build the saturating counter.
module tlul_err_gate
  import tlul_pkg::*;
#(
  parameter int unsigned      MaxOutstanding = 4,
  parameter logic [TL_DW-1:0] ErrData        = 32'hFFFF_FFFF
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  tl_h2d_t                   tl_h_i,
  output tl_d2h_t                   tl_h_o,
  input  logic                      err_i,
  output tl_h2d_t                   tl_d_o,
  input  tl_d2h_t                   tl_d_i,
  output logic [ERR_GATE_CNT_W-1:0] err_cnt_o,
  input  logic                      err_clr_i
);

  localparam int unsigned OutstW = $clog2(MaxOutstanding + 1);

  err_gate_state_e   state_q, state_d;
  logic              cap_en;
  tl_a_op_e          cap_opcode;
  logic [TL_SZW-1:0] cap_size;
  logic [TL_AIW-1:0] cap_source;

  logic              dev_a_hs, dev_d_hs;
  logic              outst_full, outst_empty;
  logic [OutstW-1:0] outst_unused;

  assign dev_a_hs = tl_d_o.a_valid & tl_d_i.a_ready;
  assign dev_d_hs = tl_d_i.d_valid & tl_d_o.d_ready;

  // Device transactions in flight.
  tlul_outst_cnt #(
    .MaxOutstanding (MaxOutstanding),
    .CntW           (OutstW)
  ) u_outst (
    .clk   (clk_i),
    .rst   (rst_i),
    .inc   (dev_a_hs),
    .dec   (dev_d_hs),
    .cnt   (outst_unused),
    .full  (outst_full),
    .empty (outst_empty)
  );

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ErrGateIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and channel steering; A is blocked by default, D passes through.
  always_comb begin
    state_d        = state_q;
    cap_en         = 1'b0;
    tl_d_o         = tl_h_i;
    tl_d_o.a_valid = 1'b0;
    tl_h_o         = tl_d_i;
    tl_h_o.a_ready = 1'b0;

    unique case (state_q)
      ErrGateIdle: begin
        if (tl_h_i.a_valid) begin
          if (err_i) begin
            // Swallow immediately only when nothing older is still pending.
            if (outst_empty) begin
              tl_h_o.a_ready = 1'b1;
              cap_en         = 1'b1;
              state_d        = ErrGateResp;
            end else begin
              state_d = ErrGateDrain;
            end
          end else if (!outst_full) begin
            tl_d_o.a_valid = 1'b1;
            tl_h_o.a_ready = tl_d_i.a_ready;
          end
        end
      end

      ErrGateDrain: begin
        if (outst_empty) begin
          state_d = ErrGateIdle;
        end
      end

      ErrGateResp: begin
        tl_h_o.d_valid  = 1'b1;
        tl_h_o.d_opcode = rsp_opcode(cap_opcode);
        tl_h_o.d_param  = '0;
        tl_h_o.d_size   = cap_size;
        tl_h_o.d_source = cap_source;
        tl_h_o.d_sink   = '0;
        tl_h_o.d_data   = (cap_opcode == Get) ? ErrData : '0;
        tl_h_o.d_error  = 1'b1;
        tl_d_o.d_ready  = 1'b0;
        if (tl_h_i.d_ready) begin
          state_d = ErrGateIdle;
        end
      end

      default: begin
        state_d = ErrGateIdle;
      end
    endcase
  end

  // Fields of the swallowed request needed to build its error response.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cap_opcode <= PutFullData;
      cap_size   <= '0;
      cap_source <= '0;
    end else if (cap_en) begin
      cap_opcode <= tl_h_i.a_opcode;
      cap_size   <= tl_h_i.a_size;
      cap_source <= tl_h_i.a_source;
    end
  end

`ifdef TLUL_ERR_GATE_CNT_EN
  logic [ERR_GATE_CNT_W-1:0] err_cnt_q;

  // Saturating reject counter; clear wins over a same-cycle increment.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_cnt_q <= '0;
    end else if (err_clr_i) begin
      err_cnt_q <= '0;
    end else if (cap_en && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + ERR_GATE_CNT_W'(1);
    end
  end

  assign err_cnt_o = err_cnt_q;
`else
  logic unused_err_clr;

  assign unused_err_clr = err_clr_i;
  assign err_cnt_o      = '0;
`endif

endmodule
